// File: rtl/crc_pkg.sv
// Shared types and helpers for the CRC frame appender: FSM states, byte width, bit reversal.
// Latency: none (package only).
// Backpressure: not applicable.
package crc_pkg;

    typedef enum logic {
        PASS   = 1'b0,
        APPEND = 1'b1
    } state_t;

    localparam int BYTE_W = 8;

    // Reverse the bit order of one byte.
    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    // Reverse the low n bits of v; bits at and above n come back as zero.
    function automatic logic [63:0] bitrev_n(input logic [63:0] v, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < n) begin
                r[i] = v[n-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One-byte CRC update: MSB-first mod-2 division of byte_in through POLY.
// Latency: purely combinational.
// Backpressure: none; the caller decides when crc_out is registered.
module crc_byte_step #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'('h04C11DB7)
) (
    input  logic [WIDTH-1:0] crc_in,
    input  logic [7:0]       byte_in,
    output logic [WIDTH-1:0] crc_out
);

    logic [WIDTH-1:0] c;

    // Align the byte with the top of the register, then shift out eight bits.
    always_comb begin
        c = crc_in ^ (WIDTH'(byte_in) << (WIDTH - 8));
        for (int i = 0; i < 8; i++) begin
            c = c[WIDTH-1] ? ((c << 1) ^ POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc_frame_append.sv
// Passes payload bytes through and appends WIDTH/8 CRC bytes after each frame; optional frame_cnt under CRC_FRAME_APPEND_STATS_EN.
// Latency: one cycle from input acceptance to m_valid; CRC bytes follow the last payload byte back to back.
// Backpressure: single output register; s_ready drops while it is full and stalled, and for the whole CRC append phase.
module crc_frame_append
    import crc_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] POLY        = WIDTH'('h04C11DB7),
    parameter bit               REFLECT_IN  = 1'b1,
    parameter logic [WIDTH-1:0] XOR_IN      = '1,
    parameter bit               REFLECT_OUT = 1'b1,
    parameter logic [WIDTH-1:0] XOR_OUT     = '1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready
`ifdef CRC_FRAME_APPEND_STATS_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int NB = WIDTH / BYTE_W;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] crc;
    logic [WIDTH-1:0] crc_next;
    logic [WIDTH-1:0] fin;
    logic [WIDTH-1:0] sr;
    logic [3:0]       idx;
    logic [7:0]       step_byte;
    logic             in_fire;
    logic             out_fire;
    logic             load_crc;

    assign step_byte = REFLECT_IN ? bitrev8(s_data) : s_data;

    crc_byte_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .crc_in  (crc),
        .byte_in (step_byte),
        .crc_out (crc_next)
    );

    // Gated by rstn so s_ready is low for the whole reset, not just after the first edge.
    assign s_ready  = rstn && (state == PASS) && (!m_valid || m_ready);
    assign in_fire  = s_valid && s_ready;
    assign out_fire = m_valid && m_ready;
    // Next CRC byte enters the output register when it is free and the final byte is not already held.
    assign load_crc = (state == APPEND) && !(m_valid && m_last) && (!m_valid || m_ready);
    assign fin      = (REFLECT_OUT ? WIDTH'(bitrev_n(64'(crc_next), WIDTH)) : crc_next) ^ XOR_OUT;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= PASS;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: last payload byte opens the append phase, last CRC byte closes it.
    always_comb begin
        state_next = state;
        case (state)
            PASS:    if (in_fire && s_last)  state_next = APPEND;
            APPEND:  if (out_fire && m_last) state_next = PASS;
            default: state_next = PASS;
        endcase
    end

    // CRC accumulator: advance on each payload byte, re-seed once the frame's CRC has left.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc <= XOR_IN;
        end else if ((state == APPEND) && out_fire && m_last) begin
            crc <= XOR_IN;
        end else if (in_fire) begin
            crc <= crc_next;
        end
    end

    // Output register: payload bytes in PASS, serialized CRC bytes in APPEND.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (in_fire) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
        end else if (load_crc) begin
            m_data  <= REFLECT_OUT ? sr[7:0] : sr[WIDTH-1 -: 8];
            m_valid <= 1'b1;
            m_last  <= (idx == 4'(NB - 1));
        end else if (out_fire) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

    // CRC shift register and byte index: latch the final CRC, then shift one byte per load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr  <= '0;
            idx <= '0;
        end else if (in_fire && s_last) begin
            sr  <= fin;
            idx <= '0;
        end else if (load_crc) begin
            sr  <= REFLECT_OUT ? (sr >> 8) : (sr << 8);
            idx <= idx + 4'd1;
        end
    end

`ifdef CRC_FRAME_APPEND_STATS_EN
    // Completed-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= '0;
        end else if (out_fire && m_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_crc_frame_append.sv
// Scoreboarded bench: CRC-32 default instance with random frames/backpressure, plus a CRC-16 instance.
// Latency: expected bytes are queued at issue time and popped by an independent monitor.
// Backpressure: m_ready on the CRC-32 instance is randomized in selected phases.
module tb_crc_frame_append;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;

    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready = 1'b1;
`ifdef CRC_FRAME_APPEND_STATS_EN
    logic [15:0] frame_cnt;
`endif

    logic [7:0] s16_data = '0;
    logic       s16_valid = 1'b0;
    logic       s16_last = 1'b0;
    logic       s16_ready;
    logic [7:0] m16_data;
    logic       m16_valid;
    logic       m16_last;
    logic       m16_ready = 1'b1;

    int tests = 0;
    int failed = 0;
    int frames_done = 0;
    int append_cycles = 0;
    int append_bad = 0;
    bit in_append = 1'b0;
    bit rand_rdy = 1'b0;

    logic [8:0] q32[$];
    logic [8:0] q16[$];
    logic [7:0] frm[0:63];

    always #5 clk = ~clk;

    crc_frame_append dut32 (
        .clk     (clk),
        .rstn    (rstn),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready)
`ifdef CRC_FRAME_APPEND_STATS_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    crc_frame_append #(
        .WIDTH       (16),
        .POLY        (16'h1021),
        .REFLECT_IN  (1'b0),
        .XOR_IN      (16'hFFFF),
        .REFLECT_OUT (1'b0),
        .XOR_OUT     (16'h0000)
    ) dut16 (
        .clk     (clk),
        .rstn    (rstn),
        .s_data  (s16_data),
        .s_valid (s16_valid),
        .s_last  (s16_last),
        .s_ready (s16_ready),
        .m_data  (m16_data),
        .m_valid (m16_valid),
        .m_last  (m16_last),
        .m_ready (m16_ready)
`ifdef CRC_FRAME_APPEND_STATS_EN
        ,
        .frame_cnt ()
`endif
    );

    // Textbook reflected CRC-32: LSB-first with the reversed polynomial.
    function automatic logic [31:0] model_crc32(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return c ^ 32'hFFFF_FFFF;
    endfunction

    task automatic push_payload32(input int n);
        for (int i = 0; i < n; i++) q32.push_back({1'b0, frm[i]});
    endtask

    task automatic push_crc32(input logic [31:0] c);
        for (int i = 0; i < 4; i++) q32.push_back({(i == 3), c[8*i +: 8]});
    endtask

    task automatic load_123456789();
        for (int i = 0; i < 9; i++) frm[i] = 8'h31 + 8'(i);
    endtask

    task automatic send_byte32(input logic [7:0] d, input logic l);
        int k;
        s_data = d;
        s_last = l;
        s_valid = 1'b1;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (s_ready) break;
        end
        if (k == 400) begin
            tests++;
            failed++;
            $display("FAIL s_ready_timeout: s_ready=%0b after 400 cycles, required 1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        if (l) in_append = 1'b1;
    endtask

    task automatic send_frame32(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send_byte32(frm[i], (i == n - 1));
            if (gaps && ($urandom_range(3) == 0)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_byte16(input logic [7:0] d, input logic l);
        int k;
        s16_data = d;
        s16_last = l;
        s16_valid = 1'b1;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (s16_ready) break;
        end
        if (k == 400) begin
            tests++;
            failed++;
            $display("FAIL s16_ready_timeout: s_ready=%0b after 400 cycles, required 1", s16_ready);
        end
        @(posedge clk);
        #1;
        s16_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        for (k = 0; k < 3000; k++) begin
            if (q32.size() == 0 && q16.size() == 0) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        tests++;
        if (q32.size() != 0 || q16.size() != 0) begin
            failed++;
            $display("FAIL drain_%s: %0d/%0d bytes still expected, required 0/0", name, q32.size(), q16.size());
        end
    endtask

    // Randomized downstream backpressure, driven just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // Monitor: compare every output transfer against the scoreboard, watch s_ready while appending.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (rstn && in_append) begin
            append_cycles++;
            if (s_ready !== 1'b0) append_bad++;
        end
        if (rstn && m_valid && m_ready) begin
            tests++;
            if (q32.size() == 0) begin
                failed++;
                $display("FAIL out32_unexpected: got data=%02h last=%0b, required no output", m_data, m_last);
            end else begin
                exp = q32.pop_front();
                if ({m_last, m_data} !== exp) begin
                    failed++;
                    $display("FAIL out32_byte: got data=%02h last=%0b, required data=%02h last=%0b",
                             m_data, m_last, exp[7:0], exp[8]);
                end
            end
            if (m_last) begin
                in_append = 1'b0;
                frames_done++;
            end
        end
        if (rstn && m16_valid && m16_ready) begin
            tests++;
            if (q16.size() == 0) begin
                failed++;
                $display("FAIL out16_unexpected: got data=%02h last=%0b, required no output", m16_data, m16_last);
            end else begin
                exp = q16.pop_front();
                if ({m16_last, m16_data} !== exp) begin
                    failed++;
                    $display("FAIL out16_byte: got data=%02h last=%0b, required data=%02h last=%0b",
                             m16_data, m16_last, exp[7:0], exp[8]);
                end
            end
        end
    end

    initial begin
        int n;
        logic [31:0] c;

        // Reset values, checked before any clock edge.
        #2 rstn = 1'b0;
        #1;
        tests++;
        if (m_valid !== 1'b0) begin failed++; $display("FAIL rst_m_valid: got %0b, required 0", m_valid); end
        tests++;
        if (m_last !== 1'b0) begin failed++; $display("FAIL rst_m_last: got %0b, required 0", m_last); end
        tests++;
        if (m_data !== 8'h00) begin failed++; $display("FAIL rst_m_data: got %02h, required 00", m_data); end
        tests++;
        if (s_ready !== 1'b0) begin failed++; $display("FAIL rst_s_ready: got %0b, required 0", s_ready); end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (s_ready !== 1'b0) begin failed++; $display("FAIL rst_s_ready_clocked: got %0b, required 0", s_ready); end
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (s_ready !== 1'b1) begin failed++; $display("FAIL idle_s_ready: got %0b, required 1", s_ready); end

        // Check value "123456789", full throughput.
        load_123456789();
        push_payload32(9);
        q32.push_back({1'b0, 8'h26});
        q32.push_back({1'b0, 8'h39});
        q32.push_back({1'b0, 8'hF4});
        q32.push_back({1'b1, 8'hCB});
        send_frame32(9, 1'b0);
        drain("check_value");

        // Single-byte frame 0x00.
        frm[0] = 8'h00;
        push_payload32(1);
        q32.push_back({1'b0, 8'h8D});
        q32.push_back({1'b0, 8'hEF});
        q32.push_back({1'b0, 8'h02});
        q32.push_back({1'b1, 8'hD2});
        send_frame32(1, 1'b0);
        drain("single_byte");

        // Two back-to-back check frames with random backpressure.
        rand_rdy = 1'b1;
        load_123456789();
        for (int f = 0; f < 2; f++) begin
            push_payload32(9);
            q32.push_back({1'b0, 8'h26});
            q32.push_back({1'b0, 8'h39});
            q32.push_back({1'b0, 8'hF4});
            q32.push_back({1'b1, 8'hCB});
        end
        send_frame32(9, 1'b0);
        send_frame32(9, 1'b0);
        drain("back_to_back");

        // Random frames against the reference model.
        for (int f = 0; f < 20; f++) begin
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) frm[i] = 8'($urandom);
            c = model_crc32(n);
            push_payload32(n);
            push_crc32(c);
            send_frame32(n, 1'b1);
        end
        drain("random");
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset after the 4th byte of a frame.
        load_123456789();
        push_payload32(4);
        for (int i = 0; i < 4; i++) send_byte32(frm[i], 1'b0);
        #1 rstn = 1'b0;
        #1;
        tests++;
        if (m_valid !== 1'b0) begin failed++; $display("FAIL async_rst_m_valid: got %0b, required 0", m_valid); end
        tests++;
        if (s_ready !== 1'b0) begin failed++; $display("FAIL async_rst_s_ready: got %0b, required 0", s_ready); end
        q32.delete();
        in_append = 1'b0;
        frames_done = 0;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        repeat (8) begin
            @(negedge clk);
            tests++;
            if (m_valid !== 1'b0) begin
                failed++;
                $display("FAIL aborted_frame_output: m_valid=%0b data=%02h, required m_valid 0", m_valid, m_data);
            end
        end
        @(posedge clk);
        #1;
        push_payload32(9);
        q32.push_back({1'b0, 8'h26});
        q32.push_back({1'b0, 8'h39});
        q32.push_back({1'b0, 8'hF4});
        q32.push_back({1'b1, 8'hCB});
        send_frame32(9, 1'b0);
        drain("after_reset");

        // CRC-16/CCITT-FALSE instance.
        for (int i = 0; i < 9; i++) q16.push_back({1'b0, 8'h31 + 8'(i)});
        q16.push_back({1'b0, 8'h29});
        q16.push_back({1'b1, 8'hB1});
        for (int i = 0; i < 9; i++) send_byte16(8'h31 + 8'(i), (i == 8));
        drain("crc16");

        tests++;
        if (append_cycles == 0 || append_bad != 0) begin
            failed++;
            $display("FAIL append_s_ready: %0d of %0d append cycles had s_ready=1, required 0 of >0",
                     append_bad, append_cycles);
        end

`ifdef CRC_FRAME_APPEND_STATS_EN
        tests++;
        if (frame_cnt !== 16'(frames_done)) begin
            failed++;
            $display("FAIL frame_cnt: got %0d, required %0d", frame_cnt, frames_done);
        end
        force dut32.frame_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut32.frame_cnt;
        frm[0] = 8'h00;
        push_payload32(1);
        q32.push_back({1'b0, 8'h8D});
        q32.push_back({1'b0, 8'hEF});
        q32.push_back({1'b0, 8'h02});
        q32.push_back({1'b1, 8'hD2});
        send_frame32(1, 1'b0);
        drain("stats_wrap");
        tests++;
        if (frame_cnt !== 16'h0000) begin
            failed++;
            $display("FAIL frame_cnt_wrap: got %04h, required 0000", frame_cnt);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/crc_frame_append.md
CRC_FRAME_APPEND -- requirements
Module: crc_frame_append

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: CRC width in bits; legal values 8, 16, 24, 32, 40, 48, 56, 64.
REQ-002 The block SHALL have parameter POLY, default 'h04C11DB7: generator polynomial, WIDTH bits, implicit top bit.
REQ-003 The block SHALL have parameter REFLECT_IN, default 1: 1 = each input byte is bit-reversed before CRC update.
REQ-004 The block SHALL have parameter XOR_IN, default all-ones: CRC register value at the start of each frame.
REQ-005 The block SHALL have parameter REFLECT_OUT, default 1: 1 = final CRC is bit-reversed over WIDTH bits.
REQ-006 The block SHALL have parameter XOR_OUT, default all-ones: value XORed into the final CRC.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-008 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port s_data, input, 8 bits: payload byte.
REQ-010 The block SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-011 The block SHALL have port s_last, input, 1 bit: s_data is the final payload byte of its frame.
REQ-012 The block SHALL have port s_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-013 The block SHALL have port m_data, output, 8 bits: payload byte or appended CRC byte.
REQ-014 The block SHALL have port m_valid, output, 1 bit: m_data is valid.
REQ-015 The block SHALL have port m_last, output, 1 bit: m_data is the final CRC byte of the frame.
REQ-016 The block SHALL have port m_ready, input, 1 bit: the downstream consumer accepts the output byte this cycle.

Function
REQ-017 A byte SHALL transfer on either side only on a clock edge where valid and ready are both 1.
- Once m_valid is asserted, m_data and m_last SHALL stay stable until the byte is accepted.
REQ-018 The block SHALL implement a two-state FSM with states PASS and APPEND; the state after reset SHALL be PASS.
REQ-019 s_ready SHALL equal (state==PASS) && (!m_valid || m_ready).
- This gives a one-entry output register with full throughput: 1 byte per cycle while m_ready is held at 1.
REQ-020 In PASS, every accepted byte SHALL be loaded into m_data with m_last=0 and m_valid=1, one cycle of latency.
- The same byte SHALL update the CRC register: crc <= step(crc, REFLECT_IN ? bitrev8(s_data) : s_data).
- The step is an MSB-first mod-2 division of the byte through POLY.
REQ-021 When an accepted byte has s_last=1, the block SHALL do the following on that same edge:
- compute fin = (REFLECT_OUT ? bitrev(crc_next) : crc_next) ^ XOR_OUT and latch it into the output shift register;
- reset the byte index to 0;
- move to APPEND.
REQ-022 In APPEND, s_ready SHALL be 0, and the block SHALL emit WIDTH/8 CRC bytes, one per output acceptance.
- If REFLECT_OUT=1, bytes SHALL go least-significant byte first; if REFLECT_OUT=0, most-significant byte first.
REQ-023 m_last SHALL be 1 only on the last CRC byte.
- When that byte is accepted, the FSM SHALL return to PASS and the CRC register SHALL load XOR_IN.
- The next frame's first byte MAY be accepted on the cycle after that acceptance.
REQ-024 A single-byte frame (first byte carries s_last) SHALL be legal and SHALL yield 1 payload byte plus WIDTH/8 CRC bytes.
- Zero-length frames are not supported.
REQ-025 When m_ready=0, all state, the CRC register and the byte index SHALL hold. No byte SHALL be dropped or duplicated.

Reset
REQ-026 While rstn=0, the block SHALL immediately and asynchronously force the following, regardless of clk:
- state=PASS, crc=XOR_IN, byte index=0;
- m_valid=0, m_last=0, m_data=0, s_ready=0.
REQ-027 When reset is asserted mid-frame, the block SHALL discard the partial frame and any pending CRC bytes.
- After release, the first accepted byte SHALL start a new frame.

Configuration
REQ-028 When macro CRC_FRAME_APPEND_STATS_EN is defined, the block SHALL add output frame_cnt, 16 bits.
- frame_cnt SHALL increment on each accepted byte with m_last=1, SHALL wrap from 0xFFFF to 0, and SHALL reset to 0.
REQ-029 When CRC_FRAME_APPEND_STATS_EN is undefined, the port and the counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 A shared package crc_pkg SHALL hold the FSM state enum, the byte-width constant 8, and bit-reverse helper functions.
REQ-031 The combinational one-byte CRC update SHALL be a sub-module named crc_byte_step.
- Its parameters SHALL be WIDTH and POLY.
- Its ports SHALL be crc_in, byte_in and crc_out.
REQ-032 The FSM, output register and CRC byte serializer SHALL reside in crc_frame_append.

Verification
REQ-033 CRC-32 defaults, frame "123456789" (0x31..0x39), m_ready=1 -> output SHALL be the 9 payload bytes, then 0x26, 0x39, 0xF4, 0xCB, with m_last on 0xCB.
REQ-034 WIDTH=16, POLY='h1021, XOR_IN='hFFFF, REFLECT_IN=0, REFLECT_OUT=0, XOR_OUT=0, frame "123456789" -> output SHALL be the payload, then 0x29, 0xB1.
REQ-035 Defaults, single-byte frame 0x00 with s_last=1 -> output SHALL be 0x00, then 0x8D, 0xEF, 0x02, 0xD2 (CRC 0xD202EF8D).
REQ-036 Defaults, "123456789" sent twice back-to-back, with m_ready toggled randomly at 50% -> both frames' output SHALL be byte-identical to REQ-033.
- s_ready SHALL be 0 throughout every APPEND phase.
REQ-037 Defaults, rstn pulsed low asynchronously mid-cycle after the 4th byte of a frame -> the following happen:
- m_valid SHALL drop without waiting for a clock edge;
- no CRC bytes SHALL be emitted for the aborted frame;
- a new "123456789" frame SHALL yield exactly the REQ-033 result.
REQ-038 With CRC_FRAME_APPEND_STATS_EN defined, 3 frames -> frame_cnt SHALL read 3.
- Preloading the counter to 0xFFFF through a bench force, followed by 1 frame -> frame_cnt SHALL read 0.
